// File: rtl/alu_operand_regs_if.sv
// Signal bundle between the control sequencer / shared bus / ALU and the
// alu_operand_regs block. The slave modport is the register block's view.
interface alu_operand_regs_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bus_in;
    logic             load_a;
    logic             load_b;
    logic             alu_wr;
    logic             sub_in;
    logic             out_a_en;
    logic             out_alu_en;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             alu_subtract;
    logic [WIDTH-1:0] bus_out;
    logic             bus_drive;
    logic             carry_flag;
    logic             zero_flag;
    logic             conflict;

    modport master (
        output bus_in, load_a, load_b, alu_wr, sub_in, out_a_en, out_alu_en,
        output alu_result, alu_carry, alu_zero,
        input  a_q, b_q, alu_subtract, bus_out, bus_drive,
        input  carry_flag, zero_flag, conflict
    );

    modport slave (
        input  bus_in, load_a, load_b, alu_wr, sub_in, out_a_en, out_alu_en,
        input  alu_result, alu_carry, alu_zero,
        output a_q, b_q, alu_subtract, bus_out, bus_drive,
        output carry_flag, zero_flag, conflict
    );
endinterface

// File: rtl/alu_operand_regs.sv
// Accumulator (A), B operand and flag registers around the external ALU.
// Define SAP1E_FLAGS_EN to implement the carry/zero flags register; otherwise flags read 0.
module alu_operand_regs #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_operand_regs_if.slave ctl
);

    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             conflict_d, conflict_q;
    logic             conflict_now;

    // A bus load wins over an ALU write-back; both together are also flagged.
    always_comb begin
        a_d = a_q;
        if (ctl.load_a) begin
            a_d = ctl.bus_in;
        end else if (ctl.alu_wr) begin
            a_d = ctl.alu_result;
        end

        b_d = b_q;
        if (ctl.load_b) begin
            b_d = ctl.bus_in;
        end

        conflict_now = (ctl.load_a & ctl.alu_wr)
                     | (ctl.out_a_en & ctl.out_alu_en)
                     | (ctl.out_a_en & ctl.load_a);
        conflict_d   = conflict_q | conflict_now;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; the reset is asynchronous, hence in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            conflict_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            conflict_q <= conflict_d;
        end
    end

`ifdef SAP1E_FLAGS_EN
    logic carry_d, carry_q;
    logic zero_d, zero_q;

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (ctl.alu_wr) begin
            carry_d = ctl.alu_carry;
            zero_d  = ctl.alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign ctl.carry_flag = carry_q;
    assign ctl.zero_flag  = zero_q;
`else
    logic unused_alu_flags;
    assign unused_alu_flags = ctl.alu_carry ^ ctl.alu_zero;
    assign ctl.carry_flag   = 1'b0;
    assign ctl.zero_flag    = 1'b0;
`endif

    assign ctl.a_q          = a_q;
    assign ctl.b_q          = b_q;
    assign ctl.conflict     = conflict_q;
    assign ctl.alu_subtract = ctl.sub_in;
    assign ctl.bus_drive    = ctl.out_a_en | ctl.out_alu_en;
    assign ctl.bus_out      = ctl.out_a_en   ? a_q            :
                              ctl.out_alu_en ? ctl.alu_result : '0;

endmodule

// File: tb/tb_alu_operand_regs.sv
// Scoreboard bench for alu_operand_regs: a driver pushes expected post-edge state
// from an arithmetic reference model; a monitor pops and compares after each edge.
module tb_alu_operand_regs;

`ifdef SAP1E_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       z;
        logic       cf;
        logic [7:0] bo;
        logic       bd;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_operand_regs_if #(.WIDTH(8)) ifc ();

    alu_operand_regs #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU stand-in; ovr forces a fixed response for collision tests.
    logic       ovr;
    logic [7:0] ovr_res;
    logic       ovr_c;
    logic       ovr_z;
    logic [8:0] alu_full;
    always_comb begin
        alu_full = ifc.alu_subtract ? ({1'b0, ifc.a_q} - {1'b0, ifc.b_q})
                                    : ({1'b0, ifc.a_q} + {1'b0, ifc.b_q});
        if (ovr) begin
            ifc.alu_result = ovr_res;
            ifc.alu_carry  = ovr_c;
            ifc.alu_zero   = ovr_z;
        end else begin
            ifc.alu_result = alu_full[7:0];
            ifc.alu_carry  = alu_full[8];
            ifc.alu_zero   = (alu_full[7:0] == 8'h00);
        end
    end

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [7:0] m_a, m_b;
    logic       m_c, m_z, m_cf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference ALU: WIDTH+1-bit sum/difference, bit 8 is carry or borrow.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int s;
        s = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return 9'(s & 32'h1FF);
    endfunction

    task automatic cycle(input logic [7:0] bi, input logic la, input logic lb, input logic wr,
                         input logic sub, input logic oa, input logic oalu);
        logic [8:0] r;
        logic       rz;
        logic [7:0] post;
        exp_t       e;
        @(negedge clk);
        ifc.bus_in     = bi;
        ifc.load_a     = la;
        ifc.load_b     = lb;
        ifc.alu_wr     = wr;
        ifc.sub_in     = sub;
        ifc.out_a_en   = oa;
        ifc.out_alu_en = oalu;

        if (ovr) begin
            r  = {ovr_c, ovr_res};
            rz = ovr_z;
        end else begin
            r  = alu_ref(m_a, m_b, sub);
            rz = (r[7:0] == 8'h00);
        end
        if ((la && wr) || (oa && oalu) || (oa && la)) m_cf = 1'b1;
        if (wr && FLAGS_EN) begin
            m_c = r[8];
            m_z = rz;
        end
        if (la)      m_a = bi;
        else if (wr) m_a = r[7:0];
        if (lb)      m_b = bi;

        post = ovr ? ovr_res : alu_ref(m_a, m_b, sub)[7:0];
        e.a  = m_a;
        e.b  = m_b;
        e.c  = m_c;
        e.z  = m_z;
        e.cf = m_cf;
        e.bo = oa ? m_a : (oalu ? post : 8'h00);
        e.bd = oa | oalu;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic idle();
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_a"},  32'(ifc.a_q),        32'd0);
        check({tag, "_b"},  32'(ifc.b_q),        32'd0);
        check({tag, "_c"},  32'(ifc.carry_flag), 32'd0);
        check({tag, "_z"},  32'(ifc.zero_flag),  32'd0);
        check({tag, "_cf"}, 32'(ifc.conflict),   32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("mon_a",     32'(ifc.a_q),        32'(mon_e.a));
                check("mon_b",     32'(ifc.b_q),        32'(mon_e.b));
                check("mon_carry", 32'(ifc.carry_flag), 32'(mon_e.c));
                check("mon_zero",  32'(ifc.zero_flag),  32'(mon_e.z));
                check("mon_confl", 32'(ifc.conflict),   32'(mon_e.cf));
                check("mon_bus",   32'(ifc.bus_out),    32'(mon_e.bo));
                check("mon_drive", 32'(ifc.bus_drive),  32'(mon_e.bd));
            end
        end
    end

    initial begin
        ovr = 1'b0; ovr_res = 8'h00; ovr_c = 1'b0; ovr_z = 1'b0;
        m_a = 8'h00; m_b = 8'h00; m_c = 1'b0; m_z = 1'b0; m_cf = 1'b0;
        ifc.bus_in = 8'h00; ifc.load_a = 1'b0; ifc.load_b = 1'b0; ifc.alu_wr = 1'b0;
        ifc.sub_in = 1'b0; ifc.out_a_en = 1'b0; ifc.out_alu_en = 1'b0;
        rst_n = 1'b0;
        #3;
        check_zero_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 5 + 3 then 8 - 3
        cycle(8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("add_a", 32'(ifc.a_q), 32'h08);
        check("add_c", 32'(ifc.carry_flag), 32'd0);
        check("add_z", 32'(ifc.zero_flag), 32'd0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain();
        check("sub_a", 32'(ifc.a_q), 32'h05);

        // wrap-around 0xFF + 0x01
        cycle(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check("wrap_a", 32'(ifc.a_q), 32'h00);
        check("wrap_c", 32'(ifc.carry_flag), 32'(FLAGS_EN));
        check("wrap_z", 32'(ifc.zero_flag),  32'(FLAGS_EN));

        // borrow 0x03 - 0x05
        cycle(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain();
        check("borrow_a", 32'(ifc.a_q), 32'hFE);
        check("borrow_c", 32'(ifc.carry_flag), 32'(FLAGS_EN));
        check("borrow_z", 32'(ifc.zero_flag), 32'd0);

        // load_b with alu_wr: A uses old B
        cycle(8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        wait_drain();
        check("no_conflict", 32'(ifc.conflict), 32'd0);

        // load_a collides with alu_wr
        ovr = 1'b1; ovr_res = 8'h22; ovr_c = 1'b1; ovr_z = 1'b0;
        cycle(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        ovr = 1'b0;
        check("collide_a", 32'(ifc.a_q), 32'h11);
        check("collide_c", 32'(ifc.carry_flag), 32'(FLAGS_EN));
        check("collide_cf", 32'(ifc.conflict), 32'd1);
        repeat (3) idle();
        wait_drain();
        check("sticky_cf", 32'(ifc.conflict), 32'd1);

        // both drivers enabled: A has priority
        cycle(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("dual_bus", 32'(ifc.bus_out), 32'h33);
        check("dual_drive", 32'(ifc.bus_drive), 32'd1);
        wait_drain();

        // asynchronous reset in mid-cycle
        cycle(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        ifc.load_a = 1'b0; ifc.out_a_en = 1'b0; ifc.out_alu_en = 1'b0;
        #2;
        check("pre_rst_a", 32'(ifc.a_q), 32'h5A);
        rst_n = 1'b0;
        #1;
        check_zero_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_a = 8'h00; m_b = 8'h00; m_c = 1'b0; m_z = 1'b0; m_cf = 1'b0;

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [7:0] bi;
            logic [2:0] sel;
            bi  = 8'($urandom);
            sel = 3'($urandom_range(0, 7));
            cycle(bi, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  (sel < 3), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
